sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM (one En_Chip_Select/En_Read/En_Write/address slice) between Nums_Req requesters, e.g. loader, compute reader and result writer.
- Uses round-robin arbitration with optional burst lock.
- Registers the SRAM command and returns read data to the requester that issued it.
- Sits between the phase controllers and each SRAM bank, so that loading, computing and writeback may overlap on the same bank.

---
 rtl/arb_pkg.sv | 14 +
 rtl/sram_port_arbiter_if.sv | 26 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/sram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM state encoding, the statistics
// counter width, and the round-robin start-index helper.
package arb_pkg;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  localparam int unsigned StatsWidth = 16;

  // Index at which a round-robin search begins, given the last winner.
  function automatic int unsigned rr_next_idx(int unsigned ptr, int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: packed per-requester commands plus grant and
// broadcast read-return signals.
interface sram_port_arbiter_if #(
  parameter int unsigned Nums_Req   = 3,
  parameter int unsigned Addr_Width = 4,
  parameter int unsigned Data_Width = 8
);
  logic [Nums_Req-1:0]            Req;
  logic [Nums_Req-1:0]            Lock;
  logic [Nums_Req-1:0]            Wr;
  logic [Nums_Req*Addr_Width-1:0] Addr_In;
  logic [Nums_Req*Data_Width-1:0] WData_In;
  logic [Nums_Req-1:0]            Grant;
  logic [Nums_Req-1:0]            RValid;
  logic [Data_Width-1:0]          RData;

  modport master (
    output Req, Lock, Wr, Addr_In, WData_In,
    input  Grant, RValid, RData
  );

  modport slave (
    input  Req, Lock, Wr, Addr_In, WData_In,
    output Grant, RValid, RData
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational masked round-robin picker: lowest set request at or above the start index,
// wrapping to the lowest set request overall.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned Nums_Req = 3,
  parameter int unsigned Id_Width = 2
) (
  input  logic [Nums_Req-1:0] req,
  input  logic [Id_Width-1:0] ptr,
  output logic [Nums_Req-1:0] onehot,
  output logic [Id_Width-1:0] idx,
  output logic                any
);
  int unsigned         start;
  logic [Nums_Req-1:0] hi_mask;
  logic [Nums_Req-1:0] sel;
  logic                found;

  always_comb begin
    start   = rr_next_idx(int'(ptr), Nums_Req);
    hi_mask = '0;
    for (int i = 0; i < int'(Nums_Req); i++) begin
      hi_mask[i] = (i >= int'(start));
    end
    sel    = (|(req & hi_mask)) ? (req & hi_mask) : req;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(Nums_Req); i++) begin
      if (sel[i] && !found) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        idx       = Id_Width'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among Nums_Req requesters with round-robin arbitration,
// burst lock and registered SRAM command/read return. ARB_STATS_EN adds grant/conflict counters.
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned Addr_Width   = 4,
  parameter int unsigned Data_Width   = 8,
  parameter int unsigned Nums_Req     = 3,
  parameter int unsigned Read_Latency = 1,
  parameter int unsigned Max_Burst    = 16,
  parameter int unsigned Id_Width     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    bus,
  output logic                  En_Chip_Select,
  output logic                  En_Read,
  output logic                  En_Write,
  output logic [Addr_Width-1:0] Addr_Out,
  output logic [Data_Width-1:0] WData_Out,
  input  logic [Data_Width-1:0] Mem_RData,
  output logic [Id_Width-1:0]   Owner,
  output logic                  Locked
`ifdef ARB_STATS_EN
  ,
  output logic [Nums_Req*StatsWidth-1:0] Grant_Count,
  output logic [StatsWidth-1:0]          Conflict_Count
`endif
);
  localparam int unsigned Depth  = Read_Latency + 1;
  localparam int unsigned BurstW = $clog2(Max_Burst + 1);

  arb_state_e          state_q, state_d;
  logic [Id_Width-1:0] rr_q, rr_d, owner_q, owner_d, blk_id_q, blk_id_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic                blk_q, blk_d;

  logic [Nums_Req-1:0] pick_oh, grant;
  logic [Id_Width-1:0] pick_idx, acc_idx;
  logic                pick_any, accept, wr_sel;

  logic [Depth-1:0]                pipe_v;
  logic [Depth-1:0][Id_Width-1:0]  pipe_id;
  logic [Nums_Req-1:0]             rvalid_q;
  logic [Data_Width-1:0]           rdata_q;

  rr_pick #(
    .Nums_Req (Nums_Req),
    .Id_Width (Id_Width)
  ) u_rr_pick (
    .req    (bus.Req),
    .ptr    (rr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    grant    = '0;
    acc_idx  = pick_idx;
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    blk_d    = blk_q;
    blk_id_d = blk_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant = pick_oh;
          rr_d  = pick_idx;
          blk_d = 1'b0;
          // A requester just force-released may not re-lock on its first accept back.
          if (bus.Lock[pick_idx] && !(blk_q && blk_id_q == pick_idx)) begin
            if (Max_Burst > 1) begin
              state_d = StLocked;
              owner_d = pick_idx;
              burst_d = BurstW'(1);
            end else begin
              blk_d    = 1'b1;
              blk_id_d = pick_idx;
            end
          end
        end
      end
      StLocked: begin
        acc_idx = owner_q;
        if (bus.Req[owner_q]) begin
          grant[owner_q] = 1'b1;
          burst_d        = burst_q + 1'b1;
          if (!bus.Lock[owner_q]) begin
            state_d = StIdle;
          end else if (32'(burst_q) + 1 == Max_Burst) begin
            state_d  = StIdle;
            blk_d    = 1'b1;
            blk_id_d = owner_q;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept    = |grant;
  assign wr_sel    = bus.Wr[acc_idx];
  assign bus.Grant = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_q     <= Id_Width'(Nums_Req - 1);
      owner_q  <= '0;
      burst_q  <= '0;
      blk_q    <= 1'b0;
      blk_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      blk_q    <= blk_d;
      blk_id_q <= blk_id_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      En_Chip_Select <= 1'b0;
      En_Read        <= 1'b0;
      En_Write       <= 1'b0;
      Addr_Out       <= '0;
      WData_Out      <= '0;
      pipe_v         <= '0;
      pipe_id        <= '0;
      rvalid_q       <= '0;
      rdata_q        <= '0;
    end else begin
      En_Chip_Select <= accept;
      En_Read        <= accept & ~wr_sel;
      En_Write       <= accept & wr_sel;
      Addr_Out  <= accept ? bus.Addr_In[int'(acc_idx)*Addr_Width +: Addr_Width] : '0;
      WData_Out <= accept ? bus.WData_In[int'(acc_idx)*Data_Width +: Data_Width] : '0;
      pipe_v[0]  <= accept & ~wr_sel;
      pipe_id[0] <= acc_idx;
      for (int k = 1; k < int'(Depth); k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
      end
      rvalid_q <= '0;
      if (pipe_v[Depth-1]) begin
        rvalid_q[pipe_id[Depth-1]] <= 1'b1;
        rdata_q                    <= Mem_RData;
      end
    end
  end

  assign bus.RValid = rvalid_q;
  assign bus.RData  = rdata_q;
  assign Owner      = owner_q;
  assign Locked     = (state_q == StLocked);

`ifdef ARB_STATS_EN
  logic [StatsWidth-1:0] gcnt_q [Nums_Req];
  logic [StatsWidth-1:0] conf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Nums_Req); i++) gcnt_q[i] <= '0;
      conf_q <= '0;
    end else begin
      for (int i = 0; i < int'(Nums_Req); i++) begin
        if (grant[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
      if ($countones(bus.Req) >= 2 && conf_q != '1) conf_q <= conf_q + 1'b1;
    end
  end

  for (genvar g = 0; g < int'(Nums_Req); g++) begin : g_stats
    assign Grant_Count[g*StatsWidth +: StatsWidth] = gcnt_q[g];
  end
  assign Conflict_Count = conf_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model and a behavioural SRAM.
module tb_sram_port_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs, rd, wr;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] wdata_out, mem_rdata;
  logic [1:0]    owner;
  logic          locked;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter_if #(.Nums_Req(NR), .Addr_Width(AW), .Data_Width(DW)) bus ();

  sram_port_arbiter #(
    .Addr_Width   (AW),
    .Data_Width   (DW),
    .Nums_Req     (NR),
    .Read_Latency (1),
    .Max_Burst    (4),
    .Id_Width     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .En_Chip_Select (cs),
    .En_Read        (rd),
    .En_Write       (wr),
    .Addr_Out       (addr_out),
    .WData_Out      (wdata_out),
    .Mem_RData      (mem_rdata),
    .Owner          (owner),
    .Locked         (locked)
  );

  always #5 clk = ~clk;

  // One-cycle-latency single-port SRAM.
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (wr) sram[addr_out] <= wdata_out;
    if (rd) mem_rdata <= sram[addr_out];
  end

  task automatic clear_cmds();
    bus.Req = '0; bus.Lock = '0; bus.Wr = '0; bus.Addr_In = '0; bus.WData_In = '0;
  endtask

  task automatic set_cmd(input int i, input bit lk, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.Req[i] = 1'b1; bus.Lock[i] = lk; bus.Wr[i] = w;
    bus.Addr_In[i*AW +: AW] = a; bus.WData_In[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    rst_n = 1'b0;
    clear_cmds();
    for (int i = 0; i < 3; i++) set_cmd(i, 1'b0, 1'b1, 4'h0, 8'(i));
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.Grant, bus.RValid, bus.RData, cs, rd, wr, addr_out, wdata_out, owner, locked}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b rvalid=%b rdata=%h cs=%b rd=%b wr=%b a=%h wd=%h own=%0d lk=%b, want all 0",
               bus.Grant, bus.RValid, bus.RData, cs, rd, wr, addr_out, wdata_out, owner, locked);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.Grant !== order[k]) begin
        errors++;
        $display("FAIL reset_rr_order[%0d]: got %b, want %b", k, bus.Grant, order[k]);
      end
    end
    @(negedge clk); clear_cmds();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_latency();
    clear_cmds(); set_cmd(0, 1'b0, 1'b1, 4'h5, 8'hA5);
    @(negedge clk); clear_cmds();
    @(negedge clk); set_cmd(1, 1'b0, 1'b0, 4'h5, 8'h00);
    #1;
    checks++;
    if (bus.Grant !== 3'b010) begin
      errors++; $display("FAIL rdlat_grant: got %b, want 010", bus.Grant);
    end
    @(negedge clk); clear_cmds();
    checks++;
    if ({cs, rd, wr, addr_out} !== {3'b110, 4'h5}) begin
      errors++;
      $display("FAIL rdlat_sram_cmd: got cs/rd/wr=%b%b%b addr=%h, want 110 addr=5", cs, rd, wr, addr_out);
    end
    @(negedge clk);
    checks++;
    if (bus.RValid !== 3'b000) begin
      errors++; $display("FAIL rdlat_early_rvalid: got %b, want 000", bus.RValid);
    end
    @(negedge clk);
    checks++;
    if (bus.RValid !== 3'b010 || bus.RData !== 8'hA5) begin
      errors++;
      $display("FAIL rdlat_return: got rvalid=%b rdata=%h, want 010 a5", bus.RValid, bus.RData);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    clear_cmds(); set_cmd(1, 1'b0, 1'b1, 4'hF, 8'h11);
    @(negedge clk);
    clear_cmds(); set_cmd(0, 1'b0, 1'b1, 4'hE, 8'h22); set_cmd(2, 1'b1, 1'b1, 4'hF, 8'h33);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) bus.Lock[2] = 1'b0;
      if (k == 4) bus.Req[2] = 1'b0;
      #1;
      checks++;
      if (bus.Grant !== ((k == 4) ? 3'b001 : 3'b100)) begin
        errors++; $display("FAIL lock_grant[%0d]: got %b, want %b", k, bus.Grant,
                           (k == 4) ? 3'b001 : 3'b100);
      end
      if (k >= 1) begin
        checks++;
        if (locked !== (k < 4) || (k < 4 && owner !== 2'd2)) begin
          errors++; $display("FAIL lock_state[%0d]: got locked=%b owner=%0d, want locked=%b owner=2",
                             k, locked, owner, k < 4);
        end
      end
    end
    @(negedge clk); clear_cmds();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_forced_release();
    logic [2:0] want;
    clear_cmds(); set_cmd(2, 1'b0, 1'b1, 4'hE, 8'h44);
    @(negedge clk);
    clear_cmds(); set_cmd(0, 1'b1, 1'b1, 4'hE, 8'h55); set_cmd(1, 1'b0, 1'b1, 4'hE, 8'h66);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) bus.Req[1] = 1'b0;
      #1;
      want = (k == 4) ? 3'b010 : 3'b001;
      checks++;
      if (bus.Grant !== want) begin
        errors++; $display("FAIL forced_release_grant[%0d]: got %b, want %b", k, bus.Grant, want);
      end
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL forced_release_unlocked: got locked=%b, want 0", locked);
    end
    @(negedge clk); clear_cmds();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mixed();
    clear_cmds(); set_cmd(0, 1'b0, 1'b1, 4'h3, 8'h3C);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (rd === 1'b1 && wr === 1'b1) begin
        errors++; $display("FAIL mixed_rd_wr_overlap[%0d]: got rd=1 wr=1, want not both", k);
      end
      if (k == 1) begin clear_cmds(); set_cmd(2, 1'b0, 1'b0, 4'h3, 8'h00); end
      if (k == 2) begin
        clear_cmds();
        checks++;
        if ({rd, wr, addr_out} !== {2'b10, 4'h3}) begin
          errors++; $display("FAIL mixed_read_cmd: got rd=%b wr=%b addr=%h, want 1 0 3", rd, wr, addr_out);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus.RValid !== 3'b100 || bus.RData !== 8'h3C) begin
          errors++; $display("FAIL mixed_return: got rvalid=%b rdata=%h, want 100 3c", bus.RValid, bus.RData);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [4];
    logic [DW-1:0] d [4];
    a[0] = 4'h5; a[1] = 4'h3; a[2] = 4'h5; a[3] = 4'h3;
    d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'hA5; d[3] = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        checks++;
        if (bus.RValid !== ((k < 7) ? 3'b010 : 3'b000) || (k < 7 && bus.RData !== d[k-3])) begin
          errors++; $display("FAIL b2b_return[%0d]: got rvalid=%b rdata=%h, want %b %h", k, bus.RValid,
                             bus.RData, (k < 7) ? 3'b010 : 3'b000, (k < 7) ? d[k-3] : 8'h00);
        end
      end
      clear_cmds();
      if (k < 4) begin
        set_cmd(1, 1'b0, 1'b0, a[k], 8'h00);
        #1;
        checks++;
        if (bus.Grant !== 3'b010) begin
          errors++; $display("FAIL b2b_grant[%0d]: got %b, want 010", k, bus.Grant);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); clear_cmds(); set_cmd(1, 1'b0, 1'b0, 4'h5, 8'h00);
    @(negedge clk); clear_cmds(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.RValid !== 3'b000) begin
        errors++; $display("FAIL midflight_no_rvalid[%0d]: got %b, want 000", k, bus.RValid);
      end
    end
  endtask

  // Reference: state after reset is IDLE with last winner = Nums_Req-1.
  task automatic test_random();
    bit            pend [3], plk [3], pwr [3];
    logic [AW-1:0] pa [3];
    logic [DW-1:0] pd [3];
    int            m_rr = 2, m_own = 0, m_cnt = 0, m_blk = -1;
    bit            m_lk = 0;
    bit            ev_rv [8], ev_dk [8];
    int            ev_id [8];
    logic [DW-1:0] ev_d [8];
    logic [DW-1:0] xm [16];
    bit            xv [16];
    bit            e_cs = 0, e_rd = 0, e_wr = 0;
    logic [AW-1:0] e_a = '0;
    logic [DW-1:0] e_wd = '0;
    logic [2:0]    want_rv, want_g;
    int            win, s;
    for (int i = 0; i < 3; i++) begin pend[i] = 0; plk[i] = 0; pwr[i] = 0; pa[i] = '0; pd[i] = '0; end
    for (int i = 0; i < 8; i++) begin ev_rv[i] = 0; ev_dk[i] = 0; ev_id[i] = 0; ev_d[i] = '0; end
    for (int i = 0; i < 16; i++) begin xv[i] = 0; xm[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      checks++;
      if ({cs, rd, wr} !== {e_cs, e_rd, e_wr} || (e_cs && addr_out !== e_a) ||
          (e_wr && wdata_out !== e_wd)) begin
        errors++; $display("FAIL rand_sram_cmd[%0d]: got %b%b%b a=%h wd=%h, want %b%b%b a=%h wd=%h",
                           cyc, cs, rd, wr, addr_out, wdata_out, e_cs, e_rd, e_wr, e_a, e_wd);
      end
      s = cyc % 8;
      want_rv = ev_rv[s] ? 3'(1 << ev_id[s]) : 3'b000;
      checks++;
      if (bus.RValid !== want_rv || (ev_rv[s] && ev_dk[s] && bus.RData !== ev_d[s])) begin
        errors++; $display("FAIL rand_return[%0d]: got rvalid=%b rdata=%h, want %b %h",
                           cyc, bus.RValid, bus.RData, want_rv, ev_d[s]);
      end
      ev_rv[s] = 0;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1; plk[i] = ($urandom_range(0, 99) < 35); pwr[i] = $urandom_range(0, 1) == 1;
          pa[i] = 4'($urandom_range(0, 15)); pd[i] = 8'($urandom);
        end
      end
      clear_cmds();
      for (int i = 0; i < 3; i++) if (pend[i]) set_cmd(i, plk[i], pwr[i], pa[i], pd[i]);
      #1;
      win = -1;
      if (m_lk) begin
        if (pend[m_own]) win = m_own;
      end else begin
        for (int j = 1; j <= 3; j++) if (win < 0 && pend[(m_rr + j) % 3]) win = (m_rr + j) % 3;
      end
      want_g = (win < 0) ? 3'b000 : 3'(1 << win);
      checks++;
      if (bus.Grant !== want_g) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b, want %b", cyc, bus.Grant, want_g);
      end
      e_cs = 0; e_rd = 0; e_wr = 0; e_a = '0; e_wd = '0;
      if (win >= 0) begin
        e_cs = 1; e_rd = !pwr[win]; e_wr = pwr[win]; e_a = pa[win]; e_wd = pd[win];
        if (pwr[win]) begin
          xm[pa[win]] = pd[win]; xv[pa[win]] = 1;
        end else begin
          s = (cyc + 3) % 8;
          ev_rv[s] = 1; ev_id[s] = win; ev_d[s] = xm[pa[win]]; ev_dk[s] = xv[pa[win]];
        end
        if (m_lk) begin
          m_cnt++;
          if (!plk[win]) m_lk = 0;
          else if (m_cnt == 4) begin m_lk = 0; m_blk = win; end
        end else begin
          m_rr = win;
          if (plk[win] && m_blk != win) begin m_lk = 1; m_own = win; m_cnt = 1; end
          m_blk = -1;
        end
        pend[win] = 0;
      end else if (m_lk) begin
        m_lk = 0;
      end
    end
    @(negedge clk); clear_cmds();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_lock();
    test_forced_release();
    test_mixed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
